// File: rtl/accel_defs.sv
// Shared definitions for the accelerometer tilt filter.
// Provides:
//   - AXIS_W: width of the signed axis reading.
//   - tilt_t: tilt code as presented on the tilt output.
//   - state_t: states of the sampling/filtering sequencer.
package accel_defs;

  localparam int AXIS_W = 16;

  typedef enum logic [1:0] {
    TILT_LEVEL = 2'b00,
    TILT_POS   = 2'b01,
    TILT_NEG   = 2'b10
  } tilt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_ACCUM   = 2'b10,
    ST_COMPARE = 2'b11
  } state_t;

endpackage

// File: rtl/accel_ring_sum.sv
// Circular sample buffer with a running sum of its contents.
// Each push retires the oldest entry and adds the new one, so the sum always
// covers the most recent 2^LOG2_DEPTH samples (zeros until the window fills).
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push       : one-cycle request to insert data
//   data       : signed sample to insert
//   sum        : signed running sum of the window
//   ready      : one-cycle pulse the cycle after a push, when sum is updated
//   full       : window holds 2^LOG2_DEPTH real samples
module accel_ring_sum
  import accel_defs::*;
#(
  parameter int LOG2_DEPTH = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic signed [AXIS_W-1:0]            data,
  output logic signed [AXIS_W+LOG2_DEPTH-1:0] sum,
  output logic                                ready,
  output logic                                full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = AXIS_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(DEPTH);

  logic signed [AXIS_W-1:0] ring_buf [DEPTH];
  logic [LOG2_DEPTH-1:0]    wp;
  logic [LOG2_DEPTH:0]      fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the buffer is cleared on reset on purpose: the running sum
      // subtracts the retired entry, so stale contents would corrupt it.
      for (int i = 0; i < DEPTH; i++) ring_buf[i] <= '0;
      wp    <= '0;
      fill  <= '0;
      sum   <= '0;
      ready <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let sum read the old ring_buf[wp]
      // in the same edge that overwrites it.
      ready <= push;
      if (push) begin
        sum          <= sum + SUM_W'(data) - SUM_W'(ring_buf[wp]);
        ring_buf[wp] <= data;
        wp           <= wp + LOG2_DEPTH'(1);
        if (fill != FILL_MAX) fill <= fill + (LOG2_DEPTH + 1)'(1);
      end
    end
  end

  assign full = (fill == FILL_MAX);

endmodule

// File: rtl/accel_tilt_filter.sv
// Moving-average filter and tilt classifier for one accelerometer axis.
// A free-running divider produces a sample tick every SAMPLE_DIV cycles; on
// an enabled tick the axis value is captured, pushed into the ring sum,
// averaged, and (once the window is full) published with a hysteretic tilt.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   axis_value   : signed axis reading, sampled only on the tick edge
//   sample_en    : gates sample ticks
//   filtered     : signed moving average (floor of sum / 2^LOG2_DEPTH)
//   filt_valid   : one-cycle pulse when filtered/tilt update
//   tilt         : 00 level, 01 positive, 10 negative
//   tilt_changed : one-cycle pulse with filt_valid when tilt changes
module accel_tilt_filter
  import accel_defs::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int LOG2_DEPTH = 3,
  parameter int THRESH     = 200,
  parameter int HYST       = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AXIS_W-1:0] axis_value,
  input  logic              sample_en,
  output logic [AXIS_W-1:0] filtered,
  output logic              filt_valid,
  output logic [1:0]        tilt,
  output logic              tilt_changed
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SUM_W = AXIS_W + LOG2_DEPTH;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]         div_cnt;
  logic                     tick;
  state_t                   state_q, state_d;
  logic signed [AXIS_W-1:0] cap;
  logic signed [AXIS_W-1:0] avg;
  logic signed [SUM_W-1:0]  ring_sum;
  logic                     ring_ready;
  logic                     ring_full;
  logic                     push;
  logic                     publish;
  tilt_t                    tilt_q, tilt_d;

  // Sample-rate divider; runs whether or not sampling is enabled.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Sequencer: state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Sequencer: next state.
  always_comb begin
    // NOTE: assigning a default first keeps every path covered so no latch
    // is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (tick && sample_en) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_ACCUM;
      ST_ACCUM:   state_d = ST_COMPARE;
      ST_COMPARE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Sequencer: outputs.
  always_comb begin
    push    = (state_q == ST_CAPTURE);
    publish = (state_q == ST_COMPARE) && ring_full;
  end

  accel_ring_sum #(
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ring (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .data  (cap),
    .sum   (ring_sum),
    .ready (ring_ready),
    .full  (ring_full)
  );

  // Capture on the enabled tick; average once the ring sum has settled.
  // The arithmetic shift floors toward -inf and always fits AXIS_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap <= '0;
      avg <= '0;
    end else begin
      if (state_q == ST_IDLE && tick && sample_en) cap <= axis_value;
      if (ring_ready) avg <= AXIS_W'(ring_sum >>> LOG2_DEPTH);
    end
  end

  // Hysteretic classifier: asserting needs |avg| > THRESH, releasing needs
  // |avg| < THRESH-HYST; a full swing flips polarity directly.
  always_comb begin
    tilt_d = tilt_q;
    case (tilt_q)
      TILT_LEVEL: begin
        if (avg > THRESH)       tilt_d = TILT_POS;
        else if (avg < -THRESH) tilt_d = TILT_NEG;
      end
      TILT_POS: begin
        if (avg < -THRESH)              tilt_d = TILT_NEG;
        else if (avg < THRESH - HYST)   tilt_d = TILT_LEVEL;
      end
      TILT_NEG: begin
        if (avg > THRESH)               tilt_d = TILT_POS;
        else if (avg > -(THRESH - HYST)) tilt_d = TILT_LEVEL;
      end
      default: tilt_d = TILT_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filtered     <= '0;
      filt_valid   <= 1'b0;
      tilt_q       <= TILT_LEVEL;
      tilt_changed <= 1'b0;
    end else begin
      filt_valid   <= publish;
      tilt_changed <= publish && (tilt_d != tilt_q);
      if (publish) begin
        filtered <= avg;
        tilt_q   <= tilt_d;
      end
    end
  end

  assign tilt = tilt_q;

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Self-checking bench for accel_tilt_filter (SAMPLE_DIV=4, 8-sample window).
// Stimulus drives samples on tick cycles (tracked by a bench-side cycle
// counter) and pushes the expected publication into a queue; the monitor
// pops and compares whenever filt_valid pulses, and otherwise checks that
// the outputs hold.
module tb_accel_tilt_filter;
  import accel_defs::*;

  localparam int SAMPLE_DIV = 4;
  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH      = 1 << LOG2_DEPTH;
  localparam int THRESH     = 200;
  localparam int HYST       = 50;

  typedef struct {
    logic [15:0] filt;
    logic [1:0]  tilt;
    logic        chg;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] axis_value = '0;
  logic        sample_en = 1'b0;
  logic [15:0] filtered;
  logic        filt_valid;
  logic [1:0]  tilt;
  logic        tilt_changed;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   hist[$];
  tilt_t tilt_m = TILT_LEVEL;
  logic [15:0] last_filt = '0;
  logic [1:0]  last_tilt = '0;

  accel_tilt_filter #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .LOG2_DEPTH(LOG2_DEPTH),
    .THRESH    (THRESH),
    .HYST      (HYST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .axis_value  (axis_value),
    .sample_en   (sample_en),
    .filtered    (filtered),
    .filt_valid  (filt_valid),
    .tilt        (tilt),
    .tilt_changed(tilt_changed)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset edge; equals the DUT divider phase.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: window of the last DEPTH samples, floor average,
  // tilt rules applied to the average.
  function automatic void model_sample(input int v);
    int    s;
    int    a;
    tilt_t nt;
    exp_t  e;
    hist.push_back(v);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    if (hist.size() < DEPTH) return;
    s = 0;
    foreach (hist[i]) s += hist[i];
    a = s / DEPTH;
    if (s < 0 && (s % DEPTH) != 0) a = a - 1;
    nt = tilt_m;
    case (tilt_m)
      TILT_LEVEL: if (a > THRESH) nt = TILT_POS; else if (a < -THRESH) nt = TILT_NEG;
      TILT_POS:   if (a < -THRESH) nt = TILT_NEG; else if (a < THRESH - HYST) nt = TILT_LEVEL;
      TILT_NEG:   if (a > THRESH) nt = TILT_POS; else if (a > -(THRESH - HYST)) nt = TILT_LEVEL;
      default:    nt = TILT_LEVEL;
    endcase
    e.filt = 16'(a);
    e.tilt = nt;
    e.chg  = (nt != tilt_m);
    tilt_m = nt;
    exp_q.push_back(e);
  endfunction

  // Drive junk between ticks, then present v/en on the tick cycle.
  task automatic sample(input int v, input bit en);
    @(negedge clk);
    while (cyc % SAMPLE_DIV != SAMPLE_DIV - 1) begin
      axis_value = 16'($urandom);
      sample_en  = 1'($urandom);
      @(negedge clk);
    end
    axis_value = 16'(v);
    sample_en  = en;
    if (en) model_sample(v);
  endtask

  task automatic samples(input int v, input int n);
    for (int i = 0; i < n; i++) sample(v, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hist.delete();
    tilt_m = TILT_LEVEL;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
      last_filt = '0;
      last_tilt = '0;
      check("reset_state", 32'({filtered, filt_valid, tilt, tilt_changed}), 32'h0);
    end else if (filt_valid) begin
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("publish", 32'({filtered, tilt, tilt_changed}), 32'({e.filt, e.tilt, e.chg}));
        last_filt = e.filt;
        last_tilt = e.tilt;
      end
    end else begin
      check("hold", 32'({filtered, tilt, tilt_changed}), 32'({last_filt, last_tilt, 1'b0}));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Fill and assert.
    samples(256, 8);
    // Hysteresis hold, then release.
    samples(160, 8);
    samples(100, 8);
    // Threshold boundaries: 200 does not assert, 150 does not release.
    samples(200, 8);
    samples(201, 8);
    samples(150, 8);
    samples(149, 8);
    // Extremes and direct polarity flip.
    samples(-32768, 8);
    samples(32767, 8);
    // Floor rounding.
    samples(1, 7);
    samples(0, 1);
    samples(-1, 7);
    samples(0, 1);

    // Gated ticks from reset, then 8 enabled ticks to the first pulse.
    do_reset();
    for (int i = 0; i < 20; i++) sample(300, 1'b0);
    samples(300, 8);

    // Reset while the sixth sample is in ACCUM.
    do_reset();
    samples(500, 6);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    hist.delete();
    tilt_m = TILT_LEVEL;
    @(negedge clk);
    reset = 1'b0;
    samples(-400, 8);

    // Randomized traffic, mostly near the thresholds.
    for (int i = 0; i < 80; i++) begin
      int v;
      bit en;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) v = int'($urandom_range(0, 700)) - 350;
      else                           v = int'($signed(16'($urandom)));
      sample(v, en);
    end

    repeat (12) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_tilt_filter.md
Name: accel_tilt_filter

Overview:
Downstream consumer of the accelerometer SPI front-end's 16-bit axis_value.
- Samples axis_value at a fixed rate.
- Smooths it with a 2^LOG2_DEPTH-sample moving average.
- Classifies the result as level, tilted positive or tilted negative, with hysteresis.
- The CPU and game logic read the filtered value and tilt code instead of raw, noisy SPI data.

Parameters:
SAMPLE_DIV, 100000, clock cycles between sample ticks (1 ms at 100 MHz); minimum 4.
LOG2_DEPTH, 3, log2 of moving-average window (8 samples); range 1..5.
THRESH, 200, signed magnitude at which tilt is declared.
HYST, 50, hysteresis; tilt releases below THRESH-HYST in magnitude.

Ports:
clk  input  1  system clock, single domain.
reset  input  1  synchronous, active-high reset.
axis_value  input  16  signed two's-complement axis reading from the accelerometer block, same clock domain.
sample_en  input  1  gates sample ticks; when low, ticks are ignored.
filtered  output  16  signed moving average.
filt_valid  output  1  one-cycle pulse when filtered/tilt update.
tilt  output  2  00 level, 01 positive, 10 negative; 11 never driven.
tilt_changed  output  1  one-cycle pulse, coincident with filt_valid, when tilt differs from its previous value.

Behaviour:
- Reset (sync, active-high, clk rising edge):
  - filtered=0, filt_valid=0, tilt=00, tilt_changed=0.
  - Divider=0, running sum=0, all buffer entries=0, fill count=0, write pointer=0, FSM=IDLE.
- Divider: counts 0..SAMPLE_DIV-1 and wraps. The tick is the cycle it equals SAMPLE_DIV-1. It runs regardless of sample_en.
- FSM states: IDLE, CAPTURE, ACCUM, COMPARE.
  - IDLE -> CAPTURE on tick && sample_en. axis_value is registered into cap on that edge.
  - CAPTURE -> ACCUM.
    - sum <= sum + cap - buf[wp].
    - buf[wp] <= cap.
    - wp increments mod 2^LOG2_DEPTH.
    - fill saturates at 2^LOG2_DEPTH.
  - ACCUM -> COMPARE. avg = sum >>> LOG2_DEPTH (arithmetic shift, truncation toward -inf), registered.
  - COMPARE -> IDLE.
    - If fill == 2^LOG2_DEPTH: filtered <= avg, filt_valid=1, tilt and tilt_changed updated.
    - Otherwise no output change and no pulse.
- Latency: tick at cycle T gives filt_valid high in cycle T+4. Sampling happens only in IDLE; ticks cannot arrive elsewhere because SAMPLE_DIV >= 4.
- Sum width: 16+LOG2_DEPTH bits, signed. No overflow possible; 8 x -32768 = -262144 fits in 19 bits.
- Tilt transitions (evaluated in COMPARE only; avg is signed):
  - 00 -> 01 if avg > THRESH.
  - 00 -> 10 if avg < -THRESH.
  - 01 -> 10 if avg < -THRESH.
  - 01 -> 00 if avg < THRESH-HYST.
  - 10 -> 01 if avg > THRESH.
  - 10 -> 00 if avg > -(THRESH-HYST).
  - Otherwise hold.
  - Boundaries: avg == THRESH does not assert; avg == THRESH-HYST does not release.
- sample_en low on a tick: no capture, buffer/sum/fill unchanged, no pulses. Outputs hold their last values.
- sample_en dropping while the FSM is past IDLE: the in-flight sample completes normally.
- Reset mid-operation (any state): next cycle is in the full reset state. A fresh 2^LOG2_DEPTH samples are needed before the first filt_valid.
- axis_value changing at any cycle other than the tick edge is ignored.

Decomposition:
- Shared package accel_defs:
  - Tilt encodings TILT_LEVEL=2'b00, TILT_POS=2'b01, TILT_NEG=2'b10.
  - FSM state encodings.
  - AXIS_W=16.
- Natural sub-module: accel_ring_sum. It holds the circular buffer, write pointer, fill counter and running sum, with a one-cycle push/ready interface. accel_tilt_filter keeps the divider, FSM, averaging and hysteresis classifier.

Test Plan:
All scenarios use SAMPLE_DIV=4, LOG2_DEPTH=3, THRESH=200, HYST=50.
1. Fill and assert: reset, sample_en=1, axis_value=16'h0100 (256) steady.
   - Ticks 1-7: no filt_valid.
   - Tick 8: filt_valid at tick+4 with filtered=16'h0100, tilt=01, tilt_changed=1.
2. Hysteresis hold/release:
   - After scenario 1, drive 160 for 8 samples: avg reaches 160 > 150, tilt stays 01, tilt_changed never pulses.
   - Then drive 100 for 8 samples: tilt->00 on the first sample where avg < 150, with one tilt_changed pulse.
3. Negative extreme: 8 samples of 16'h8000 -> filtered=16'h8000, tilt=10. Then 8 samples of 16'h7FFF -> filtered=16'h7FFF, tilt=01 directly (single tilt_changed per transition).
4. Rounding: samples 1,1,1,1,1,1,1,0 -> sum=7, filtered=0. Samples of -1 with one 0 -> filtered=16'hFFFF (floor).
5. Gating: sample_en=0 across 20 ticks with axis_value=300 -> no filt_valid; filtered/tilt unchanged; sum/fill unchanged, checked by re-enabling and counting 8 ticks to the first pulse from reset.
6. Reset mid-operation: assert reset for one cycle while the FSM is in ACCUM after 6 samples -> all outputs 0 next cycle; first filt_valid only after 8 new ticks.
